// File: rtl/morse_key_decoder_if.sv
// Key-side bus of the Morse decoder: tick/key in, one letter record out.
interface morse_key_decoder_if;
  logic       tick;
  logic       key;
  logic       sym_valid;
  logic [2:0] sym_len;
  logic [4:0] sym_bits;
  logic       sym_err;

  modport master (
    output tick, key,
    input  sym_valid, sym_len, sym_bits, sym_err
  );

  modport slave (
    input  tick, key,
    output sym_valid, sym_len, sym_bits, sym_err
  );
endinterface

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times presses and gaps on a tick base, classifies dots
// and dashes, and emits one registered letter record per letter gap.
module morse_key_decoder #(
  parameter int unsigned DOT_MAX    = 3,
  parameter int unsigned LETTER_GAP = 7,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  morse_key_decoder_if.slave  bus
);

  localparam int unsigned LEN_W    = 3;
  localparam int unsigned MAX_ELEM = 5;

  localparam logic [CNT_W-1:0] DOT_LIMIT = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(LETTER_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_ELEM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 key_m, key_s;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [LEN_W-1:0]     len, len_nxt;
  logic [MAX_ELEM-1:0]  bits, bits_nxt;
  logic                 err, err_nxt;

  logic                 out_valid, out_valid_nxt;
  logic [LEN_W-1:0]     out_len, out_len_nxt;
  logic [MAX_ELEM-1:0]  out_bits, out_bits_nxt;
  logic                 out_err, out_err_nxt;

  // Two-flop synchronizer for the asynchronous key level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= bus.key;
      key_s <= key_m;
    end
  end

  // Saturating duration increment; a held key never wraps back to a dot.
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

  // State, duration, letter assembly and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      bits      <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_len   <= '0;
      out_bits  <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      len       <= len_nxt;
      bits      <= bits_nxt;
      err       <= err_nxt;
      out_valid <= out_valid_nxt;
      out_len   <= out_len_nxt;
      out_bits  <= out_bits_nxt;
      out_err   <= out_err_nxt;
    end
  end

  // Next-state: classify on release, terminate the letter on a full gap.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    len_nxt       = len;
    bits_nxt      = bits;
    err_nxt       = err;
    out_valid_nxt = 1'b0;
    out_len_nxt   = out_len;
    out_bits_nxt  = out_bits;
    out_err_nxt   = out_err;

    unique case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
        end
      end

      PRESS: begin
        if (key_s) begin
          if (bus.tick) cnt_nxt = cnt_inc;
        end else begin
          if (len < LEN_FULL) begin
            bits_nxt[len] = (cnt > DOT_LIMIT);
            len_nxt       = len + LEN_W'(1);
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end

      GAP: begin
        if (bus.tick && (cnt == GAP_LAST)) begin
          // A press landing on the terminating cycle starts a fresh letter.
          out_valid_nxt = (len != '0);
          out_len_nxt   = len;
          out_bits_nxt  = bits;
          out_err_nxt   = err;
          len_nxt       = '0;
          bits_nxt      = '0;
          err_nxt       = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = key_s ? PRESS : IDLE;
        end else if (key_s) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
        end else if (bus.tick) begin
          cnt_nxt = cnt_inc;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.sym_valid = out_valid;
  assign bus.sym_len   = out_len;
  assign bus.sym_bits  = out_bits;
  assign bus.sym_err   = out_err;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: a duration/element-list model checked every
// cycle, plus literal expectations for each directed letter.
module tb_morse_key_decoder;

  localparam int DOT_MAX    = 3;
  localparam int LETTER_GAP = 7;
  localparam int CNT_MAXV   = 255;

  logic clk;
  logic rst;

  morse_key_decoder_if bus ();

  morse_key_decoder #(
    .DOT_MAX   (DOT_MAX),
    .LETTER_GAP(LETTER_GAP),
    .CNT_W     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: synchronizer delay line, last key level seen, duration,
  // and the full list of elements of the current letter (can exceed 5).
  logic       s1, s2, prev_ks;
  int         dur;
  bit         elems[$];
  logic       e_valid;
  logic [2:0] e_len;
  logic [4:0] e_bits;
  logic       e_err;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] bits;
    logic       err;
  } rec_t;
  rec_t recs[$];

  // Behavioural model: measure press/gap lengths in ticks and emit letters.
  always @(posedge clk or posedge rst) begin
    logic ks;
    logic tk;
    if (rst) begin
      s1 = 0; s2 = 0; prev_ks = 0; dur = 0;
      elems.delete();
      e_valid = 0; e_len = 0; e_bits = 0; e_err = 0;
    end else begin
      ks = s2; s2 = s1; s1 = bus.key; tk = bus.tick;
      e_valid = 0;
      if (prev_ks) begin
        if (ks) begin
          if (tk && dur < CNT_MAXV) dur++;
        end else begin
          elems.push_back(dur > DOT_MAX);
          dur = 0;
        end
      end else if (elems.size() > 0) begin
        if (tk && dur == LETTER_GAP - 1) begin
          e_valid = 1;
          e_len   = (elems.size() > 5) ? 3'd5 : 3'(elems.size());
          e_bits  = '0;
          for (int i = 0; i < 5 && i < elems.size(); i++) e_bits[i] = elems[i];
          e_err   = (elems.size() > 5);
          elems.delete();
          dur = 0;
        end else if (ks) begin
          dur = 0;
        end else if (tk && dur < CNT_MAXV) begin
          dur++;
        end
      end else begin
        dur = 0;
      end
      prev_ks = ks;
    end
  end

  // Every-cycle comparison against the model, plus a log of emitted records.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (bus.sym_valid !== e_valid || bus.sym_len !== e_len ||
          bus.sym_bits !== e_bits || bus.sym_err !== e_err) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got v=%0b len=%0d bits=%05b err=%0b want v=%0b len=%0d bits=%05b err=%0b",
                 $time, bus.sym_valid, bus.sym_len, bus.sym_bits, bus.sym_err,
                 e_valid, e_len, e_bits, e_err);
      end
      if (bus.sym_valid === 1'b1) recs.push_back({bus.sym_len, bus.sym_bits, bus.sym_err});
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input int idx,
                           input logic [2:0] len, input logic [4:0] bits, input logic err);
    n_checks++;
    if (idx >= recs.size()) begin
      n_fail++;
      $display("FAIL %s missing record %0d (have %0d)", name, idx, recs.size());
    end else if (recs[idx].len !== len || recs[idx].bits !== bits || recs[idx].err !== err) begin
      n_fail++;
      $display("FAIL %s got len=%0d bits=%05b err=%0b want len=%0d bits=%05b err=%0b",
               name, recs[idx].len, recs[idx].bits, recs[idx].err, len, bits, err);
    end
  endtask

  // Hold key/tick for n clock cycles; called and returns on a falling edge.
  task automatic drive(input logic k, input logic t, input int n);
    for (int i = 0; i < n; i++) begin
      bus.key  = k;
      bus.tick = t;
      @(negedge clk);
    end
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.key = 1'b0;
    bus.tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", int'(bus.sym_valid), 0);
    check_val("rst_len",   int'(bus.sym_len),   0);
    check_val("rst_bits",  int'(bus.sym_bits),  0);
    check_val("rst_err",   int'(bus.sym_err),   0);
    rst = 1'b0;
    drive(0, 1, 4);

    // Letter A: dot (2 ticks) then dash (6 ticks).
    base = recs.size();
    drive(1, 1, 3); drive(0, 1, 2); drive(1, 1, 7); drive(0, 1, 14);
    check_val("a_count", recs.size() - base, 1);
    check_rec("a_rec", base, 3'd2, 5'b00010, 1'b0);

    // Classification boundary: 3 ticks is a dot, 4 ticks is a dash.
    base = recs.size();
    drive(1, 1, 4); drive(0, 1, 14);
    drive(1, 1, 5); drive(0, 1, 14);
    check_val("et_count", recs.size() - base, 2);
    check_rec("e_rec", base,     3'd1, 5'b00000, 1'b0);
    check_rec("t_rec", base + 1, 3'd1, 5'b00001, 1'b0);

    // Overflow: six dots, then a normal letter clears the error.
    base = recs.size();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 2);
      drive(0, 1, (i == 5) ? 14 : 3);
    end
    drive(1, 1, 2); drive(0, 1, 14);
    check_val("ovf_count", recs.size() - base, 2);
    check_rec("ovf_rec",  base,     3'd5, 5'b00000, 1'b1);
    check_rec("post_ovf", base + 1, 3'd1, 5'b00000, 1'b0);

    // Gap one short of a letter gap, then a long tick stall mid-gap.
    base = recs.size();
    drive(1, 1, 2); drive(0, 1, 6); drive(1, 1, 7); drive(0, 1, 3);
    drive(0, 0, 200);
    check_val("stall_none", recs.size() - base, 0);
    drive(0, 1, 14);
    check_val("stall_count", recs.size() - base, 1);
    check_rec("stall_rec", base, 3'd2, 5'b00010, 1'b0);

    // Key rises on the very cycle the gap completes.
    base = recs.size();
    drive(1, 1, 2); drive(0, 1, 7); drive(1, 1, 7); drive(0, 1, 14);
    check_val("simul_count", recs.size() - base, 2);
    check_rec("simul_first",  base,     3'd1, 5'b00000, 1'b0);
    check_rec("simul_second", base + 1, 3'd1, 5'b00001, 1'b0);

    // Asynchronous reset in the middle of a press.
    base = recs.size();
    drive(1, 1, 4);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", int'(bus.sym_valid), 0);
    check_val("arst_len",   int'(bus.sym_len),   0);
    check_val("arst_bits",  int'(bus.sym_bits),  0);
    check_val("arst_err",   int'(bus.sym_err),   0);
    @(negedge clk);
    drive(0, 1, 3);
    rst = 1'b0;
    drive(0, 1, 3);
    drive(1, 1, 2); drive(0, 1, 14);
    check_val("arst_count", recs.size() - base, 1);
    check_rec("arst_rec", base, 3'd1, 5'b00000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
